calc_keypad_encoder: RTL

Scans a 4x4 matrix keypad, debounces each press and emits one 6-bit calculator code word per press: a 2-bit mode field plus a 4-bit key index. A valid/ack handshake presents the word to the calculator's control/decode path. This block is the producing end of that path's 6-bit input word. It sits between the board keypad pins and the control decoder.

---
 rtl/calc_keypad_encoder.sv | 134 +++++++++++++
 1 files changed

// File: rtl/calc_keypad_encoder.sv
// 4x4 active-low keypad scanner: debounces one press and emits {sel, key} under a valid/ack handshake.
// A press emits once; a press that arrives while the previous word is unconsumed is dropped and sets overrun.
module calc_keypad_encoder #(
    parameter int SCAN_DIV = 1000,
    parameter int DEBOUNCE = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row,
    input  logic [1:0] sel,
    input  logic       ack,
    output logic [3:0] col,
    output logic [5:0] code,
    output logic       valid,
    output logic       overrun
);
    localparam int SW = $clog2(SCAN_DIV);
    localparam int CW = $clog2(DEBOUNCE + 1);
    localparam logic [SW-1:0] SLOT_LAST = SW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] CNT_DONE  = CW'(DEBOUNCE);

    typedef enum logic [1:0] {S_SCAN, S_DEB, S_EMIT, S_REL} state_t;

    state_t        state_q;
    logic [3:0]    row_s1_q;
    logic [3:0]    row_s2_q;
    logic [SW-1:0] slot_q;
    logic [CW-1:0] cnt_q;
    logic [1:0]    col_idx_q;
    logic [1:0]    row_idx_q;
    logic [3:0]    col_q;
    logic [5:0]    code_q;
    logic          valid_q;
    logic          overrun_q;

    logic          sample;
    logic [CW-1:0] cnt_inc;
    logic [1:0]    low_idx;

    assign sample  = (slot_q == SLOT_LAST);
    assign cnt_inc = cnt_q + CW'(1);

    // Lowest-numbered low row wins when several keys share the driven column.
    always_comb begin
        low_idx = 2'd3;
        if (!row_s2_q[0])      low_idx = 2'd0;
        else if (!row_s2_q[1]) low_idx = 2'd1;
        else if (!row_s2_q[2]) low_idx = 2'd2;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_SCAN;
            row_s1_q  <= 4'hF;
            row_s2_q  <= 4'hF;
            slot_q    <= '0;
            cnt_q     <= '0;
            col_idx_q <= 2'd0;
            row_idx_q <= 2'd0;
            col_q     <= 4'b1110;
            code_q    <= 6'h00;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            row_s1_q <= row;
            row_s2_q <= row_s1_q;
            slot_q   <= sample ? '0 : slot_q + SW'(1);

            if (valid_q && ack) begin
                valid_q <= 1'b0;
            end

            case (state_q)
                S_SCAN: begin
                    if (sample) begin
                        if (!(&row_s2_q)) begin
                            row_idx_q <= low_idx;
                            cnt_q     <= '0;
                            state_q   <= S_DEB;
                        end else begin
                            col_idx_q <= col_idx_q + 2'd1;
                            col_q     <= {col_q[2:0], col_q[3]};
                        end
                    end
                end
                S_DEB: begin
                    if (sample) begin
                        if (!row_s2_q[row_idx_q]) begin
                            cnt_q <= cnt_inc;
                            if (cnt_inc == CNT_DONE) begin
                                state_q <= S_EMIT;
                            end
                        end else begin
                            state_q   <= S_SCAN;
                            col_idx_q <= col_idx_q + 2'd1;
                            col_q     <= {col_q[2:0], col_q[3]};
                        end
                    end
                end
                S_EMIT: begin
                    // An ack in this same cycle frees the slot, so the new word replaces the old one.
                    if (!valid_q || ack) begin
                        code_q  <= {sel, row_idx_q, col_idx_q};
                        valid_q <= 1'b1;
                    end else begin
                        overrun_q <= 1'b1;
                    end
                    cnt_q   <= '0;
                    state_q <= S_REL;
                end
                S_REL: begin
                    if (sample) begin
                        if (&row_s2_q) begin
                            cnt_q <= cnt_inc;
                            if (cnt_inc == CNT_DONE) begin
                                state_q   <= S_SCAN;
                                col_idx_q <= col_idx_q + 2'd1;
                                col_q     <= {col_q[2:0], col_q[3]};
                            end
                        end else begin
                            cnt_q <= '0;
                        end
                    end
                end
                default: state_q <= S_SCAN;
            endcase
        end
    end

    assign col     = col_q;
    assign code    = code_q;
    assign valid   = valid_q;
    assign overrun = overrun_q;
endmodule
